// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller between ID and EX: tracks in-flight destinations,
// emits registered per-operand forward selects and a combinational load-use stall.
module hazard_forward_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_READ   = 2,
   parameter int FWD_STAGES = 2,
   parameter int LOAD_LAT   = 1,
   parameter int SEL_W      = $clog2(FWD_STAGES + 1),
   parameter int CNT_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           id_valid,
   input  logic [NUM_READ*REG_ADDR_W-1:0] id_rs,
   input  logic [NUM_READ-1:0]            id_rs_used,
   input  logic [REG_ADDR_W-1:0]          id_rd,
   input  logic                           id_regwrite,
   input  logic                           id_memread,
   input  logic                           flush,
   output logic                           stall,
   output logic [NUM_READ*SEL_W-1:0]      fwd_sel,
   output logic [CNT_W-1:0]               stall_cnt
);

   // Slot FWD_STAGES is never examined (its value comes from the register file),
   // so only slots 0..FWD_STAGES-1 are stored.
   logic [FWD_STAGES-1:0]   r_valid;
   logic [FWD_STAGES-1:0]   r_regwrite;
   logic [FWD_STAGES-1:0]   r_memread;
   logic [REG_ADDR_W-1:0]   r_rd [FWD_STAGES];
   logic [NUM_READ*SEL_W-1:0] r_fwd_sel;
   logic [CNT_W-1:0]        r_stall_cnt;

   logic [NUM_READ*SEL_W-1:0] w_sel_flat;
   logic [NUM_READ-1:0]       w_haz;
   logic                      w_issue;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_READ; gi++) begin : g_op
         logic [REG_ADDR_W-1:0] w_rs;
         logic [SEL_W-1:0]      w_sel;
         logic                  w_load_hit;

         assign w_rs = id_rs[gi*REG_ADDR_W +: REG_ADDR_W];

         // Scan oldest to youngest so the youngest match overwrites older ones.
         always_comb begin
            w_sel      = '0;
            w_load_hit = 1'b0;
            for (int p = FWD_STAGES - 1; p >= 0; p--) begin
               if (id_rs_used[gi] && (w_rs != '0) && r_valid[p] &&
                   r_regwrite[p] && (r_rd[p] == w_rs)) begin
                  w_sel      = SEL_W'(p + 1);
                  w_load_hit = r_memread[p] && (p < LOAD_LAT);
               end
            end
         end

         assign w_sel_flat[gi*SEL_W +: SEL_W] = w_sel;
         assign w_haz[gi]                     = w_load_hit;
      end
   endgenerate

   assign stall   = id_valid & (|w_haz) & ~flush;
   assign w_issue = id_valid & ~stall & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid     <= '0;
         r_regwrite  <= '0;
         r_memread   <= '0;
         r_fwd_sel   <= '0;
         r_stall_cnt <= '0;
         for (int p = 0; p < FWD_STAGES; p++) begin
            r_rd[p] <= '0;
         end
      end else begin
         r_valid    <= {r_valid[FWD_STAGES-2:0], w_issue};
         r_regwrite <= {r_regwrite[FWD_STAGES-2:0], w_issue & id_regwrite};
         r_memread  <= {r_memread[FWD_STAGES-2:0], w_issue & id_memread};
         r_rd[0]    <= id_rd;
         for (int p = 1; p < FWD_STAGES; p++) begin
            r_rd[p] <= r_rd[p-1];
         end
         r_fwd_sel <= w_issue ? w_sel_flat : '0;
         if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   assign fwd_sel   = r_fwd_sel;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: directed plan scenarios followed by
// randomized traffic, checked against a history-based reference model.
module tb_hazard_forward_ctrl;
   localparam int RW = 5;
   localparam int NR = 2;
   localparam int FS = 2;
   localparam int LL = 1;
   localparam int SW = $clog2(FS + 1);
   localparam int CW = 4;   // narrow counter so saturation is reachable quickly

   logic              clk = 1'b0;
   logic              rst, id_valid, id_regwrite, id_memread, flush;
   logic [NR*RW-1:0]  id_rs;
   logic [NR-1:0]     id_rs_used;
   logic [RW-1:0]     id_rd;
   logic              stall;
   logic [NR*SW-1:0]  fwd_sel;
   logic [CW-1:0]     stall_cnt;

   always #5 clk = ~clk;

   hazard_forward_ctrl #(
      .REG_ADDR_W(RW), .NUM_READ(NR), .FWD_STAGES(FS), .LOAD_LAT(LL),
      .SEL_W(SW), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
      .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .flush(flush), .stall(stall),
      .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
   );

   typedef struct {bit v; int rd; bit rw; bit mr;} ent_t;
   typedef struct {bit chk_stall; bit stall; int fwd; int cnt;} exp_t;

   ent_t hist[$];   // hist[a] = instruction a stages past EX
   exp_t sbq[$];
   int   m_fwd, m_cnt;
   bit   m_stall;
   int   checks   = 0;
   int   failures = 0;
   int   txn      = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit v, input int rs0, input int rs1,
                             input bit [1:0] used, input int rd, input bit rw,
                             input bit mr, input bit fl);
      int   rs_a[NR];
      int   sel[NR];
      bit   haz, found, issue;
      ent_t n;
      exp_t e;
      rs_a[0] = rs0;
      rs_a[1] = rs1;
      haz = 1'b0;
      for (int i = 0; i < NR; i++) begin
         sel[i] = 0;
         found  = 1'b0;
         for (int a = 0; a < FS; a++) begin
            if (!found && used[i] && rs_a[i] != 0 && hist[a].v && hist[a].rw &&
                hist[a].rd == rs_a[i]) begin
               found  = 1'b1;
               sel[i] = a + 1;
               if (hist[a].mr && a < LL) haz = 1'b1;
            end
         end
      end
      m_stall = v && haz && !fl;
      issue   = v && !m_stall && !fl;
      e.chk_stall = !r;
      e.stall     = m_stall;
      if (r) begin
         for (int a = 0; a < FS; a++) hist[a].v = 1'b0;
         m_fwd = 0;
         m_cnt = 0;
      end else begin
         n.v = issue; n.rd = rd; n.rw = rw; n.mr = mr;
         hist.push_front(n);
         void'(hist.pop_back());
         m_fwd = issue ? (sel[0] + sel[1] * (1 << SW)) : 0;
         if (m_stall && m_cnt < (1 << CW) - 1) m_cnt++;
      end
      e.fwd = m_fwd;
      e.cnt = m_cnt;
      sbq.push_back(e);
   endtask

   task automatic step(input bit r, input bit v, input int rs0, input int rs1,
                       input bit [1:0] used, input int rd, input bit rw,
                       input bit mr, input bit fl);
      @(posedge clk);
      #1;
      rst         = r;
      id_valid    = v;
      id_rs       = {RW'(rs1), RW'(rs0)};
      id_rs_used  = used;
      id_rd       = RW'(rd);
      id_regwrite = rw;
      id_memread  = mr;
      flush       = fl;
      model_step(r, v, rs0, rs1, used, rd, rw, mr, fl);
      #1;
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
   endtask

   // Monitor: each negedge checks the current stall against the newest record
   // and the registered outputs against the record from the previous cycle.
   initial begin
      exp_t pend;
      exp_t e;
      bit   have;
      have = 1'b0;
      forever begin
         @(negedge clk);
         if (have) begin
            chk("sb_fwd_sel", fwd_sel, pend.fwd);
            chk("sb_stall_cnt", stall_cnt, pend.cnt);
            $display("txn %0d stall=%0b fwd_sel=%0h stall_cnt=%0d",
                     txn, stall, fwd_sel, stall_cnt);
            txn++;
            have = 1'b0;
         end
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.chk_stall) chk("sb_stall", stall, e.stall);
            pend = e;
            have = 1'b1;
         end
      end
   end

   initial begin
      bit s_v, s_rw, s_mr, s_fl, s_r;
      int s_rs0, s_rs1, s_rd;
      bit [1:0] s_used;
      ent_t b;
      b.v = 0; b.rd = 0; b.rw = 0; b.mr = 0;
      for (int a = 0; a < FS; a++) hist.push_back(b);
      m_fwd = 0; m_cnt = 0; m_stall = 0;
      rst = 1'b1; id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
      id_regwrite = 0; id_memread = 0; flush = 0;

      step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      chk("reset_fwd", fwd_sel, 0);
      chk("reset_cnt", stall_cnt, 0);

      // no dependence
      step(0, 1, 0, 0, 2'b00, 1, 1, 0, 0);
      step(0, 1, 0, 0, 2'b00, 2, 1, 0, 0);
      step(0, 1, 3, 4, 2'b11, 9, 0, 0, 0);
      chk("nodep_stall", stall, 0);
      nop();
      chk("nodep_fwd", fwd_sel, 0);

      // back-to-back ALU chain
      step(0, 1, 0, 0, 2'b00, 3, 1, 0, 0);
      step(0, 1, 3, 4, 2'b11, 10, 0, 0, 0);
      chk("alu_stall", stall, 0);
      step(0, 1, 4, 3, 2'b11, 0, 0, 0, 0);
      chk("alu_fwd_op0", fwd_sel, 4'b0001);
      nop();
      chk("alu_fwd_op1", fwd_sel, 4'b1000);

      // load-use
      step(0, 1, 0, 0, 2'b00, 5, 1, 1, 0);
      step(0, 1, 5, 0, 2'b01, 11, 1, 0, 0);
      chk("lu_stall", stall, 1);
      chk("lu_cnt0", stall_cnt, 0);
      step(0, 1, 5, 0, 2'b01, 11, 1, 0, 0);
      chk("lu_stall_end", stall, 0);
      chk("lu_cnt1", stall_cnt, 1);
      chk("lu_stall_sel", fwd_sel, 0);
      nop();
      chk("lu_fwd", fwd_sel, 4'b0010);

      // youngest match shadows older load; x0 never matches
      step(0, 1, 0, 0, 2'b00, 7, 1, 1, 0);
      step(0, 1, 0, 0, 2'b00, 7, 1, 0, 0);
      step(0, 1, 7, 7, 2'b11, 0, 1, 0, 0);
      chk("prio_stall", stall, 0);
      step(0, 1, 0, 0, 2'b11, 12, 0, 0, 0);
      chk("prio_fwd", fwd_sel, 4'b0101);
      chk("x0_stall", stall, 0);
      nop();
      chk("x0_fwd", fwd_sel, 0);

      // flush colliding with a load-use hazard
      step(0, 1, 0, 0, 2'b00, 6, 1, 1, 0);
      step(0, 1, 6, 6, 2'b11, 13, 1, 0, 1);
      chk("fl_stall", stall, 0);
      step(0, 1, 6, 0, 2'b01, 14, 0, 0, 0);
      chk("fl_fwd", fwd_sel, 0);
      chk("fl_bubble_stall", stall, 0);
      nop();
      chk("fl_late_fwd", fwd_sel, 4'b0010);

      // drive the counter into saturation
      for (int k = 0; k < 16; k++) begin
         step(0, 1, 0, 0, 2'b00, 5, 1, 1, 0);
         step(0, 1, 5, 0, 2'b01, 11, 0, 0, 0);
         step(0, 1, 5, 0, 2'b01, 11, 0, 0, 0);
      end
      nop();
      chk("sat_cnt", stall_cnt, 15);

      // reset with a load in flight
      step(0, 1, 0, 0, 2'b00, 8, 1, 1, 0);
      step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      step(0, 1, 8, 0, 2'b01, 15, 0, 0, 0);
      chk("rst_stall", stall, 0);
      chk("rst_cnt", stall_cnt, 0);
      nop();
      chk("rst_fwd", fwd_sel, 0);

      // randomized traffic; a stalled instruction is usually held in ID
      s_v = 0; s_rs0 = 0; s_rs1 = 0; s_used = 0; s_rd = 0; s_rw = 0; s_mr = 0;
      for (int n = 0; n < 400; n++) begin
         if (!(m_stall && $urandom_range(0, 4) != 0)) begin
            s_v    = $urandom_range(0, 5) != 0;
            s_rs0  = $urandom_range(0, 7);
            s_rs1  = $urandom_range(0, 7);
            s_used = 2'($urandom_range(0, 3));
            s_rd   = $urandom_range(0, 7);
            s_rw   = $urandom_range(0, 3) != 0;
            s_mr   = $urandom_range(0, 2) == 0;
         end
         s_fl = $urandom_range(0, 9) == 0;
         s_r  = $urandom_range(0, 79) == 0;
         step(s_r, s_v, s_rs0, s_rs1, s_used, s_rd, s_rw, s_mr, s_fl);
      end
      nop();
      nop();
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("sb_drain", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised hazard and forwarding controller for the in-order pipeline, sitting between ID and EX. It tracks every issued instruction's destination register in an internal slot pipeline. It produces registered per-operand forward selects aligned with the consumer's EX cycle, and a combinational load-use stall for any depth of forwarding network. It also handles branch flush bubbles and keeps a saturating stall-cycle counter.

## Interface
- REG_ADDR_W, 5, register address width
- NUM_READ, 2, read operands per instruction
- FWD_STAGES, 2, forwarding sources after EX (1 = EX/MEM, 2 = MEM/WB, ...); ≥2
- LOAD_LAT, 1, extra stages before load data is forwardable; 1 ≤ LOAD_LAT < FWD_STAGES
- SEL_W, $clog2(FWD_STAGES+1), derived select width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  instruction present in ID
- id_rs  in  NUM_READ*REG_ADDR_W  source registers; operand i at bits [i*REG_ADDR_W +: REG_ADDR_W]
- id_rs_used  in  NUM_READ  operand i actually read
- id_rd  in  REG_ADDR_W  destination register
- id_regwrite  in  1  instruction writes id_rd
- id_memread  in  1  instruction is a load
- flush  in  1  branch taken in EX; kill ID instruction
- stall  out  1  combinational; hold PC and IF/ID, insert bubble
- fwd_sel  out  NUM_READ*SEL_W  registered per-operand select: 0 = register file, k = forwarding source k
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Tracker: slots 0..FWD_STAGES. Slot 0 is the instruction now in EX; slot p is p stages past EX. Each slot holds {valid, rd, regwrite, memread}.
- Every cycle the tracker shifts (slot p → p+1, oldest dropped). Slot 0 is loaded from ID on issue; otherwise it is loaded with a bubble (valid=0).
- Issue = id_valid & ~stall & ~flush.
- Match for operand i at slot p: id_rs_used[i] & id_rs[i]≠0 & slot p valid & regwrite & rd==id_rs[i]. Only p in 0..FWD_STAGES-1 is examined, since slot FWD_STAGES leaves next cycle and is read from the register file.
- Youngest match (smallest p) wins. Candidate select = p+1.
- Load-use: if the youngest match is a load (memread) with p < LOAD_LAT, the hazard is set. stall = id_valid & hazard(any operand) & ~flush.
- A load in an older slot (p ≥ LOAD_LAT) forwards normally. A younger non-load match shadows an older load, and no stall results.
- x0 never matches: no forwarding and no stall.
- fwd_sel register: on issue, takes the candidate selects (0 where no match). On stall, flush or no issue, it is cleared to 0.
- Priority: rst > flush > stall > issue.
- flush and hazard in the same cycle: flush wins, stall=0, bubble inserted.
- stall_cnt increments each cycle stall=1 and holds at all-ones (no wrap).

## Timing
- Reset values: all slots invalid, fwd_sel=0, stall_cnt=0. stall=0 from the first cycle after reset.
- rst mid-operation clears all in-flight tracking on that edge. No forwarding references pre-reset instructions.
- fwd_sel latency: computed in the ID cycle, valid for the whole following EX cycle.
- stall has zero latency and is purely combinational from ID inputs and tracker state. There is no loop through fwd_sel.
- Load-use with LOAD_LAT=1: exactly 1 stall cycle, then the consumer issues with select 2. Generally, LOAD_LAT−p stall cycles for a match at slot p.
- Back-to-back dependent ALU ops: no stall, select 1.

## Test plan
- No dependence: rs={3,4}, tracker holding rd=1,2 → stall=0, next cycle fwd_sel={0,0}.
- ALU chain: issue rd=3 regwrite, then rs={3,4} → next cycle fwd_sel op0=1, op1=0. One cycle later, an instruction with rs={4,3} → op1=2.
- Load-use (LOAD_LAT=1): issue load rd=5, then rs={5,0} → stall=1 for 1 cycle and stall_cnt=1, then issue with fwd_sel op0=2.
- Priority and x0: slots hold rd=7 (slot 0, ALU) and rd=7 (slot 1, load) → select 1, no stall. rs=0 matching a writer of rd=0 → select 0.
- Flush collision: load-use hazard with flush=1 in the same cycle → stall=0, fwd_sel=0, slot 0 bubble. stall_cnt forced to 0xFFFF plus one stall → stays 0xFFFF.
- Reset mid-flight: rst=1 with a load in slot 0 → next cycle a dependent instruction gets stall=0, fwd_sel=0, stall_cnt=0.
